// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the fetch front end and the control unit.
package cpu_pkg;

    // Fetch FSM states: a request is outstanding, a stale request is being
    // drained after a redirect, or the skid buffer is full and fetch is parked.
    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DISCARD = 2'd1,
        ST_HOLD    = 2'd2
    } fetch_state_t;

    // Instruction field positions handed to the control unit.
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    // Byte distance between consecutive instruction words.
    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/ifid_skid.sv
// ifid_skid: one-entry buffer that catches a fetched word while IF/ID is stalled.
module ifid_skid #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [31:0]       in_instr,
    input  logic [ADDR_W-1:0] in_pc4,
    output logic              full,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc4
);

    // Clear wins over load; the entry only ever holds one word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full  <= 1'b0;
            instr <= '0;
            pc4   <= '0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= in_instr;
            pc4   <= in_pc4;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with IF/ID register, redirect handling
// and a one-entry skid buffer for stalls.
// Optional build macro: IF_STAGE_PERF_CNT_EN adds the fetch_count output.
module if_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              ifid_valid,
    output logic [31:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc4,
    output logic [5:0]        opCode,
    output logic [5:0]        func
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    fetch_state_t      state, state_nx;
    logic [ADDR_W-1:0] pc, stale_addr, pc_seq, target;
    logic              started;
    logic              ack_ok, fetch_ack, word_to_ifid;
    logic              skid_load, skid_clear, skid_full;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc4;

    assign pc_seq       = pc + ADDR_W'(PC_STEP);
    assign target       = branch_target & ~ADDR_W'(3);
    assign imem_req     = started && (state != ST_HOLD);
    assign imem_addr    = (state == ST_DISCARD) ? stale_addr : pc;
    assign ack_ok       = imem_ack && imem_req;
    assign fetch_ack    = (state == ST_FETCH) && ack_ok;
    assign word_to_ifid = !branch_taken && !stall &&
                          (fetch_ack || ((state == ST_HOLD) && skid_full));
    assign skid_load    = !branch_taken && stall && fetch_ack;
    assign skid_clear   = branch_taken || ((state == ST_HOLD) && !stall);
    assign opCode       = ifid_instr[OPCODE_MSB:OPCODE_LSB];
    assign func         = ifid_instr[FUNCT_MSB:FUNCT_LSB];

    // Requests stay low during reset and rise on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nx;
    end

    // Next state: a redirect with a request still in flight must drain its stale ack.
    always_comb begin
        state_nx = state;
        case (state)
            ST_FETCH: begin
                if (branch_taken)
                    state_nx = (ack_ok || !imem_req) ? ST_FETCH : ST_DISCARD;
                else if (ack_ok && stall)
                    state_nx = ST_HOLD;
            end
            ST_DISCARD: begin
                if (ack_ok) state_nx = ST_FETCH;
            end
            ST_HOLD: begin
                if (branch_taken || !stall) state_nx = ST_FETCH;
            end
            default: state_nx = ST_FETCH;
        endcase
    end

    // Fetch PC, plus a copy of the address still being fetched while draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            stale_addr <= RESET_PC;
        end else begin
            if (state != ST_DISCARD) stale_addr <= pc;
            if (branch_taken)        pc <= target;
            else if (fetch_ack)      pc <= pc_seq;
        end
    end

    // IF/ID register: holds under stall, bubbles when nothing new arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid_valid <= 1'b0;
            ifid_instr <= '0;
            ifid_pc4   <= '0;
        end else if (branch_taken) begin
            ifid_valid <= 1'b0;
        end else if (!stall) begin
            ifid_valid <= word_to_ifid;
            if (word_to_ifid) begin
                ifid_instr <= (state == ST_HOLD) ? skid_instr : imem_rdata;
                ifid_pc4   <= (state == ST_HOLD) ? skid_pc4   : pc_seq;
            end
        end
    end

`ifdef IF_STAGE_PERF_CNT_EN
    // Counts words that actually land in IF/ID; dropped words never get there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)            fetch_count <= '0;
        else if (word_to_ifid) fetch_count <= fetch_count + 32'd1;
    end
`endif

    ifid_skid #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (skid_load),
        .clear    (skid_clear),
        .in_instr (imem_rdata),
        .in_pc4   (pc_seq),
        .full     (skid_full),
        .instr    (skid_instr),
        .pc4      (skid_pc4)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a
// transaction-level model of the fetch front end.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic [5:0]  op_code;
    logic [5:0]  func_f;
    logic [31:0] fetch_count;

    logic        w_stall, w_branch, w_req, w_ack, w_valid;
    logic [31:0] w_target, w_addr, w_rdata, w_instr, w_pc4, w_count;
    logic [5:0]  w_op, w_func;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the front end in terms of fetched words and where they sit.
    bit          m_started;
    logic [31:0] m_fetch_pc;
    bit          m_stale;
    logic [31:0] m_stale_addr;
    bit          m_ifid_valid;
    logic [31:0] m_ifid_instr, m_ifid_pc4;
    bit          m_skid_valid;
    logic [31:0] m_skid_instr, m_skid_pc4;
    logic [31:0] m_count;

    if_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .ifid_valid    (ifid_valid),
        .ifid_instr    (ifid_instr),
        .ifid_pc4      (ifid_pc4),
        .opCode        (op_code),
        .func          (func_f)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    if_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (w_stall),
        .branch_taken  (w_branch),
        .branch_target (w_target),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (w_ack),
        .imem_rdata    (w_rdata),
        .ifid_valid    (w_valid),
        .ifid_instr    (w_instr),
        .ifid_pc4      (w_pc4),
        .opCode        (w_op),
        .func          (w_func)
`ifdef IF_STAGE_PERF_CNT_EN
        ,
        .fetch_count   (w_count)
`endif
    );

`ifndef IF_STAGE_PERF_CNT_EN
    assign fetch_count = 32'd0;
    assign w_count     = 32'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        if (a == 32'd0) return 32'h0000_0020;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started    = 1'b0;
        m_fetch_pc   = 32'd0;
        m_stale      = 1'b0;
        m_stale_addr = 32'd0;
        m_ifid_valid = 1'b0;
        m_ifid_instr = 32'd0;
        m_ifid_pc4   = 32'd0;
        m_skid_valid = 1'b0;
        m_skid_instr = 32'd0;
        m_skid_pc4   = 32'd0;
        m_count      = 32'd0;
    endtask

    // Advance the model by one clock using the rules for words, redirects and stalls.
    task automatic model_step(bit s, bit b, logic [31:0] t, bit a);
        bit req_now, acc, word_in;
        req_now   = m_started && !m_skid_valid;
        acc       = a && req_now;
        m_started = 1'b1;
        if (b) begin
            if (!m_stale && req_now && !acc) begin
                m_stale      = 1'b1;
                m_stale_addr = m_fetch_pc;
            end else if (m_stale && acc) begin
                m_stale = 1'b0;
            end
            m_fetch_pc   = t & 32'hFFFF_FFFC;
            m_ifid_valid = 1'b0;
            m_skid_valid = 1'b0;
        end else begin
            word_in = acc && !m_stale;
            if (acc && m_stale) m_stale = 1'b0;
            if (s) begin
                if (word_in) begin
                    m_skid_valid = 1'b1;
                    m_skid_instr = mem_word(m_fetch_pc);
                    m_skid_pc4   = m_fetch_pc + 32'd4;
                end
            end else if (m_skid_valid) begin
                m_ifid_valid = 1'b1;
                m_ifid_instr = m_skid_instr;
                m_ifid_pc4   = m_skid_pc4;
                m_skid_valid = 1'b0;
                m_count      = m_count + 32'd1;
            end else begin
                m_ifid_valid = word_in;
                if (word_in) begin
                    m_ifid_instr = mem_word(m_fetch_pc);
                    m_ifid_pc4   = m_fetch_pc + 32'd4;
                    m_count      = m_count + 32'd1;
                end
            end
            if (word_in) m_fetch_pc = m_fetch_pc + 32'd4;
        end
    endtask

    task automatic check_output();
        check("imem_req",   {31'd0, imem_req},   {31'd0, m_started && !m_skid_valid});
        check("imem_addr",  imem_addr,           m_stale ? m_stale_addr : m_fetch_pc);
        check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_ifid_valid});
        check("ifid_instr", ifid_instr,          m_ifid_instr);
        check("ifid_pc4",   ifid_pc4,            m_ifid_pc4);
        check("opCode",     {26'd0, op_code},    (m_ifid_instr >> 26) & 32'h3F);
        check("func",       {26'd0, func_f},     m_ifid_instr & 32'h3F);
`ifdef IF_STAGE_PERF_CNT_EN
        check("fetch_count", fetch_count, m_count);
`endif
    endtask

    // One clock: drive inputs just after the falling edge, check, then step the model.
    task automatic apply_stimulus(bit s, bit b, logic [31:0] t, bit a);
        stall         = s;
        branch_taken  = b;
        branch_target = t;
        imem_ack      = a;
        imem_rdata    = mem_word(imem_addr);
        #1 check_output();
        @(posedge clk);
        model_step(s, b, t, a);
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a cycle with an ack on the bus.
    task automatic mid_reset();
        stall        = 1'b0;
        branch_taken = 1'b0;
        imem_ack     = 1'b1;
        imem_rdata   = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_output();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output();
        rst_n    = 1'b1;
        imem_ack = 1'b0;
    endtask

    initial begin
        bit s, b, a;
        logic [31:0] t;
        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        w_stall = 1'b0; w_branch = 1'b0; w_target = 32'd0;
        w_ack = 1'b1; w_rdata = 32'hABCD_0001;
        model_reset();
        repeat (3) @(negedge clk);
        check_output();
        check("wrap_req_rst", {31'd0, w_req}, 32'd0);
        rst_n = 1'b1;

        // Start-up sequence and the first word.
        apply_stimulus(0, 0, 32'd0, 0);
        check("addr0", imem_addr, 32'h0);
        check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
        check("wrap_req0", {31'd0, w_req}, 32'd1);
        apply_stimulus(0, 0, 32'd0, 1);
        check("first_valid", {31'd0, ifid_valid}, 32'd1);
        check("first_op", {26'd0, op_code}, 32'h00);
        check("first_func", {26'd0, func_f}, 32'h20);
        check("pc4_seq0", ifid_pc4, 32'h4);
        check("addr1", imem_addr, 32'h4);
        check("wrap_addr1", w_addr, 32'h0);
        apply_stimulus(0, 0, 32'd0, 1);
        check("pc4_seq1", ifid_pc4, 32'h8);
        check("addr2", imem_addr, 32'h8);
        check("wrap_pc4", w_pc4, 32'h4);
`ifdef IF_STAGE_PERF_CNT_EN
        check("wrap_count", w_count, 32'd2);
`endif
        apply_stimulus(0, 0, 32'd0, 1);
        check("pc4_seq2", ifid_pc4, 32'hC);

        // Ack under a three-cycle stall lands in the skid buffer.
        apply_stimulus(1, 0, 32'd0, 1);
        check("hold_req", {31'd0, imem_req}, 32'd0);
        check("hold_pc4", ifid_pc4, 32'hC);
        apply_stimulus(1, 0, 32'd0, 0);
        apply_stimulus(1, 0, 32'd0, 0);
        check("hold_pc4_b", ifid_pc4, 32'hC);
        apply_stimulus(0, 0, 32'd0, 0);
        check("skid_pc4", ifid_pc4, 32'h10);
        check("resume_addr", imem_addr, 32'h10);
        check("resume_req", {31'd0, imem_req}, 32'd1);

        // Redirect with a request in flight: the stale ack is drained.
        apply_stimulus(0, 1, 32'h0000_0103, 0);
        check("discard_addr", imem_addr, 32'h10);
        check("discard_valid", {31'd0, ifid_valid}, 32'd0);
        apply_stimulus(0, 0, 32'd0, 0);
        apply_stimulus(0, 0, 32'd0, 1);
        check("target_addr", imem_addr, 32'h100);
        check("target_wait_valid", {31'd0, ifid_valid}, 32'd0);
        apply_stimulus(0, 0, 32'd0, 1);
        check("target_pc4", ifid_pc4, 32'h104);

        // Redirect coincident with ack and stall: word dropped, no skid.
        apply_stimulus(1, 1, 32'h0000_0200, 1);
        check("drop_addr", imem_addr, 32'h200);
        check("drop_req", {31'd0, imem_req}, 32'd1);
        check("drop_valid", {31'd0, ifid_valid}, 32'd0);
        apply_stimulus(0, 0, 32'd0, 1);
        check("drop_next_pc4", ifid_pc4, 32'h204);

        // Randomized interleavings of stall, redirect and ack latency.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) mid_reset();
            s = ($urandom_range(0, 99) < 30);
            b = ($urandom_range(0, 99) < 8);
            t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF5 : $urandom;
            a = imem_req ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 5);
            apply_stimulus(s, b, t, a);
        end
        check_output();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter ADDR_W, default 32, is the PC and instruction-memory address width.
REQ-003 clk  input  1  is the single rising-edge clock.
REQ-004 rst_n  input  1  is the asynchronous, active-low reset.
REQ-005 stall  input  1  is the hazard-unit hold request for the IF/ID register.
REQ-006 branch_taken  input  1  is a single-cycle redirect pulse from decode.
REQ-007 branch_target  input  ADDR_W  is the redirect address, valid when branch_taken=1.
REQ-008 imem_req  output  1  is the instruction-memory request.
REQ-009 imem_addr  output  ADDR_W  is the word-aligned fetch address.
REQ-010 imem_ack  input  1  is the one-cycle response strobe, accepted only while imem_req=1.
REQ-011 imem_rdata  input  32  is the instruction word, valid with imem_ack.
REQ-012 ifid_valid  output  1  is high when the IF/ID register holds a live instruction.
REQ-013 ifid_instr  output  32  is the latched instruction.
REQ-014 ifid_pc4  output  ADDR_W  is the latched instruction address +4.
REQ-015 opCode  output  6  is ifid_instr[31:26], for the control unit.
REQ-016 func  output  6  is ifid_instr[5:0], for the control unit.

Function
REQ-017 The FSM SHALL have three states: FETCH (request outstanding), DISCARD (outstanding request made stale by a redirect), and HOLD (skid buffer full, no request).
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack.
REQ-019 On imem_ack in FETCH with stall=0, the instruction SHALL be written to IF/ID on the same edge: ifid_valid=1 and ifid_pc4=pc+4. On that edge pc SHALL become pc+4, and the next request SHALL be issued on the following cycle.
REQ-020 When stall=1, ifid_valid, ifid_instr and ifid_pc4 SHALL hold their values.
REQ-021 On imem_ack in FETCH with stall=1, the word and its pc+4 SHALL be captured in a one-entry skid buffer, and the FSM SHALL enter HOLD with imem_req=0.
REQ-022 In HOLD, the first cycle with stall=0 SHALL move the skid entry into IF/ID, and the FSM SHALL return to FETCH.
REQ-023 When branch_taken=1, pc SHALL load {branch_target[ADDR_W-1:2],2'b00} on that edge; ifid_valid and the skid entry SHALL be cleared.
REQ-024 branch_taken SHALL take priority over stall and over a simultaneous imem_ack. The acked word SHALL be dropped, and the FSM SHALL go to FETCH at the new pc.
REQ-025 When branch_taken=1 in FETCH without imem_ack, the FSM SHALL enter DISCARD. imem_req SHALL stay 1 with the old address until the stale ack, which SHALL be dropped, and the FSM SHALL then return to FETCH at the target.
REQ-026 PC increment SHALL wrap modulo 2^ADDR_W (for ADDR_W=32, 32'hFFFF_FFFC+4 = 32'h0000_0000).
REQ-027 A branch_taken in DISCARD SHALL update the pending target only.
REQ-028 The block SHALL lose and duplicate no instruction under any interleaving of stall and imem_ack.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately set the following: pc=RESET_PC, state FETCH, imem_req=0, ifid_valid=0, ifid_instr=0, ifid_pc4=0, opCode=0, func=0, skid empty.
REQ-030 imem_req SHALL first rise on the first clk edge after rst_n deasserts.
REQ-031 Reset asserted mid-request SHALL abandon the request, and any imem_ack arriving during reset SHALL be ignored.

Configuration
REQ-032 With IF_STAGE_PERF_CNT_EN defined, the block SHALL add output fetch_count [31:0]. The counter SHALL reset to 0, increment by 1 on each word written into IF/ID, wrap at 2^32, and exclude dropped words.
REQ-033 Without IF_STAGE_PERF_CNT_EN, neither the fetch_count port nor its logic SHALL exist; all other behaviour is identical.

Structure
REQ-034 The shared package cpu_pkg SHALL hold the FSM state enumeration, the opcode/funct field bit positions, and the constant PC_STEP=4.
REQ-035 The one-entry skid buffer SHALL be a sub-module named ifid_skid.

Verification
REQ-036 Reset with rst_n low, then release, with 1-cycle ack -> imem_addr sequence 0x0, 0x4, 0x8, with ifid_pc4 0x4, 0x8, 0xC.
REQ-037 imem_rdata=32'h0000_0020 acked -> opCode=6'b000000, func=6'b100000, ifid_valid=1 on the next cycle.
REQ-038 stall=1 for 3 cycles while an ack arrives -> IF/ID unchanged, HOLD entered, imem_req=0; on stall release, the skid word appears once and fetch resumes at the next address.
REQ-039 branch_taken with branch_target=0x0000_0103 and no ack pending -> DISCARD; the stale ack is dropped, the next imem_addr=0x0000_0100, and ifid_valid=0 until the target word arrives.
REQ-040 branch_taken coincident with imem_ack and stall=1 -> the word is dropped, the skid stays empty, and the next request is to the target.
REQ-041 RESET_PC=32'hFFFF_FFFC -> the second fetch address is 0x0; with IF_STAGE_PERF_CNT_EN, fetch_count=2 after two accepted words.
